// File: rtl/result_writeback_if.sv
// Result stream (engine -> write-back) and RAM write port, bundled for result_writeback.
// The master modport is the write-back block; slave is the engine/RAM side.
interface result_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              result_ready;
  logic              RAM_grant;
  logic              RAM_write;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_bus;

  modport master (
    input  result_valid, result_data, RAM_grant,
    output result_ready, RAM_write, RAM_address, RAM_bus
  );

  modport slave (
    output result_valid, result_data, RAM_grant,
    input  result_ready, RAM_write, RAM_address, RAM_bus
  );
endinterface

// File: rtl/result_writeback.sv
// Write-back DMA: buffers engine results in a small FIFO and writes them row-major to RAM
// from a base address, then pulses finish_write for one cycle.
module result_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [4:0]        outSize,
  input  logic              relu,
  output logic              busy,
  output logic              finish_write,
  result_writeback_if.master wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              relu_q, relu_d;
  logic [9:0]        total_q, total_d;
  logic [9:0]        cnt_in_q, cnt_in_d;
  logic [9:0]        cnt_out_q, cnt_out_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              ready_q, ready_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_bus_q, ram_bus_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;

  logic [9:0]        total_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] push_word_s;

  assign total_s     = {5'd0, outSize} * {5'd0, outSize};
  assign push_s      = ready_q && wb.result_valid && (state_q == S_RUN);
  assign pop_s       = (state_q == S_RUN) && (count_q != {CNT_W{1'b0}}) && wb.RAM_grant;
  assign push_word_s = (relu_q && wb.result_data[DATA_W-1]) ? {DATA_W{1'b0}} : wb.result_data;

  // Next-state logic: job control, FIFO bookkeeping and the registered RAM write port.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    relu_d      = relu_q;
    total_d     = total_q;
    cnt_in_d    = cnt_in_q;
    cnt_out_d   = cnt_out_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_bus_d   = ram_bus_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = address;
          relu_d    = relu;
          total_d   = total_s;
          cnt_in_d  = 10'd0;
          cnt_out_d = 10'd0;
          wr_ptr_d  = {PTR_W{1'b0}};
          rd_ptr_d  = {PTR_W{1'b0}};
          count_d   = {CNT_W{1'b0}};
          state_d   = (total_s == 10'd0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (push_s) begin
          mem_d[wr_ptr_q] = push_word_s;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          cnt_in_d        = cnt_in_q + 10'd1;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        // The address offset is the write index, so it wraps modulo 2^ADDR_W with the base.
        if (pop_s) begin
          ram_write_d = 1'b1;
          ram_bus_d   = mem_q[rd_ptr_q];
          ram_addr_d  = base_q + ADDR_W'(cnt_out_q);
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          cnt_out_d   = cnt_out_q + 10'd1;
          state_d     = ((cnt_out_q + 10'd1) == total_q) ? S_DONE : S_RUN;
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_RUN);
    finish_d = (state_q == S_DONE);
    ready_d  = (state_d == S_RUN) && (count_d != FULL_CNT) && (cnt_in_d < total_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= {ADDR_W{1'b0}};
      relu_q      <= 1'b0;
      total_q     <= 10'd0;
      cnt_in_q    <= 10'd0;
      cnt_out_q   <= 10'd0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      ready_q     <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_bus_q   <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      relu_q      <= relu_d;
      total_q     <= total_d;
      cnt_in_q    <= cnt_in_d;
      cnt_out_q   <= cnt_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
      ready_q     <= ready_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_bus_q   <= ram_bus_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  assign wb.result_ready = ready_q;
  assign wb.RAM_write    = ram_write_q;
  assign wb.RAM_address  = ram_addr_q;
  assign wb.RAM_bus      = ram_bus_q;
  assign busy            = busy_q;
  assign finish_write    = finish_q;
endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: directed scenarios plus a randomized
// valid/grant run checked against a transaction-level model of the job.
module tb_result_writeback;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] address;
  logic [4:0]    out_size;
  logic          relu;
  logic          busy;
  logic          finish_write;

  result_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  result_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .address      (address),
    .outSize      (out_size),
    .relu         (relu),
    .busy         (busy),
    .finish_write (finish_write),
    .wb           (wb)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int            cyc;
  int            acc;
  int            fin_cnt;
  int            fin_cyc;
  int            ready_seen;
  int            valid_pct;
  int            grant_pct;
  logic [DW-1:0] feed_q [$];
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc [$];

  // One clock: account for the handshake seen before the edge, then observe after it.
  task automatic tick();
    bit hs;
    hs = wb.result_valid && wb.result_ready;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc++;
    if (hs) begin
      acc++;
      if (feed_q.size() > 0) feed_q.delete(0);
    end
    if (wb.RAM_write) begin
      obs_addr.push_back(wb.RAM_address);
      obs_data.push_back(wb.RAM_bus);
      obs_cyc.push_back(cyc);
    end
    if (finish_write) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (wb.result_ready) ready_seen++;
    wb.result_valid = (feed_q.size() > 0) && ($urandom_range(99) < valid_pct);
    wb.result_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
    wb.RAM_grant    = ($urandom_range(99) < grant_pct);
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [4:0] n, input logic r);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    cyc        = 0;
    acc        = 0;
    fin_cnt    = 0;
    fin_cyc    = -1;
    ready_seen = 0;
    address    = a;
    out_size   = n;
    relu       = r;
    start      = 1'b1;
    wb.result_valid = (feed_q.size() > 0);
    wb.result_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
    wb.RAM_grant    = ($urandom_range(99) < grant_pct);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (wb.result_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", wb.result_ready); end
    checks++; if (wb.RAM_write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b want 0", wb.RAM_write); end
    checks++; if (wb.RAM_address !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", wb.RAM_address); end
    checks++; if (wb.RAM_bus !== 16'h0000) begin failures++; $display("FAIL reset_bus: got %h want 0000", wb.RAM_bus); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (finish_write !== 1'b0) begin failures++; $display("FAIL reset_finish: got %b want 0", finish_write); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    feed_q    = {16'd1, 16'd2, 16'd3, 16'd4};
    valid_pct = 100;
    grant_pct = 100;
    do_start(16'h0100, 5'd2, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_run: got %b want 1", busy); end
    checks++; if (wb.result_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_first: got %b want 1", wb.result_ready); end
    repeat (12) tick();
    checks++; if (obs_addr.size() != 4) begin failures++; $display("FAIL basic_count: got %0d writes want 4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== 16'h0100 + 16'(i) || obs_data[i] !== 16'(i + 1) || obs_cyc[i] != 3 + i) begin
        failures++;
        $display("FAIL basic_write%0d: got (%h,%h)@%0d want (%h,%h)@%0d", i, obs_addr[i], obs_data[i],
                 obs_cyc[i], 16'h0100 + 16'(i), 16'(i + 1), 3 + i);
      end
    end
    checks++; if (fin_cnt != 1 || fin_cyc != 7) begin failures++; $display("FAIL basic_finish: got %0d pulses @%0d want 1 @7", fin_cnt, fin_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_relu_wrap();
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ed = '{16'h0000, 16'h0007, 16'h0000, 16'h0003};
    feed_q    = {16'hFFFB, 16'h0007, 16'h8000, 16'h0003};
    valid_pct = 100;
    grant_pct = 100;
    do_start(16'hFFFE, 5'd2, 1'b1);
    repeat (12) tick();
    checks++; if (obs_addr.size() != 4) begin failures++; $display("FAIL relu_count: got %0d writes want 4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL relu_write%0d: got (%h,%h) want (%h,%h)", i, obs_addr[i], obs_data[i], ea[i], ed[i]);
      end
    end
    checks++; if (fin_cnt != 1) begin failures++; $display("FAIL relu_finish: got %0d pulses want 1", fin_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [9];
    logic [AW-1:0] base;
    base = AW'($urandom);
    feed_q.delete();
    for (int i = 0; i < 9; i++) begin
      vals[i] = DW'($urandom);
      feed_q.push_back(vals[i]);
    end
    valid_pct = 100;
    grant_pct = 0;
    do_start(base, 5'd3, 1'b0);
    repeat (20) tick();
    checks++; if (acc != DEPTH) begin failures++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
    checks++; if (wb.result_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %b want 0", wb.result_ready); end
    checks++; if (obs_addr.size() != 0) begin failures++; $display("FAIL bp_stalled: got %0d writes want 0", obs_addr.size()); end
    grant_pct = 100;
    repeat (25) tick();
    checks++; if (obs_addr.size() != 9) begin failures++; $display("FAIL bp_count: got %0d writes want 9", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 9; i++) begin
      checks++;
      if (obs_addr[i] !== base + AW'(i) || obs_data[i] !== vals[i]) begin
        failures++;
        $display("FAIL bp_write%0d: got (%h,%h) want (%h,%h)", i, obs_addr[i], obs_data[i], base + AW'(i), vals[i]);
      end
    end
    checks++; if (fin_cnt != 1) begin failures++; $display("FAIL bp_finish: got %0d pulses want 1", fin_cnt); end
  endtask

  task automatic test_degenerate();
    int acc_before;
    feed_q    = {16'h1111, 16'h2222, 16'h3333};
    valid_pct = 100;
    grant_pct = 100;
    do_start(16'h0040, 5'd0, 1'b0);
    // A start arriving while the DONE cycle is pending must be ignored.
    out_size = 5'd0;
    start    = 1'b1;
    repeat (5) tick();
    checks++; if (fin_cnt != 1 || fin_cyc != 2) begin failures++; $display("FAIL zero_finish: got %0d pulses @%0d want 1 @2", fin_cnt, fin_cyc); end
    checks++; if (obs_addr.size() != 0) begin failures++; $display("FAIL zero_writes: got %0d want 0", obs_addr.size()); end
    checks++; if (ready_seen != 0 || acc != 0) begin failures++; $display("FAIL zero_ready: got ready_cycles=%0d accepted=%0d want 0,0", ready_seen, acc); end
    feed_q    = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    grant_pct = 0;
    do_start(16'h0300, 5'd2, 1'b0);
    repeat (3) tick();
    address  = 16'h0500;
    out_size = 5'd1;
    start    = 1'b1;
    tick();
    grant_pct = 100;
    repeat (15) tick();
    checks++; if (obs_addr.size() != 4) begin failures++; $display("FAIL busy_start_count: got %0d writes want 4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== 16'h0300 + 16'(i)) begin
        failures++;
        $display("FAIL busy_start_addr%0d: got %h want %h", i, obs_addr[i], 16'h0300 + 16'(i));
      end
    end
    checks++; if (fin_cnt != 1) begin failures++; $display("FAIL busy_start_finish: got %0d pulses want 1", fin_cnt); end
    acc_before = acc;
    feed_q = {16'h7777, 16'h6666};
    repeat (4) tick();
    checks++; if (acc != acc_before || wb.result_ready !== 1'b0) begin failures++; $display("FAIL idle_accept: got accepted=%0d ready=%b want %0d,0", acc, wb.result_ready, acc_before); end
    feed_q.delete();
    tick();
  endtask

  task automatic test_random();
    localparam int TOTAL = 961;
    logic [DW-1:0] vals [$];
    logic [AW-1:0] base;
    logic          r;
    logic          exp_rdy;
    logic [DW-1:0] exp_d;
    bit            ready_bad;
    base = AW'($urandom);
    r    = 1'($urandom_range(1));
    feed_q.delete();
    for (int i = 0; i < TOTAL + 10; i++) begin
      vals.push_back(DW'($urandom));
      feed_q.push_back(vals[i]);
    end
    valid_pct = 50;
    grant_pct = 50;
    do_start(base, 5'd31, r);
    ready_bad = 1'b0;
    for (int i = 0; i < 20000 && fin_cnt == 0; i++) begin
      tick();
      // Occupancy is everything accepted minus everything already written.
      exp_rdy = (obs_addr.size() < TOTAL) && (acc - obs_addr.size() < DEPTH) && (acc < TOTAL);
      if (!ready_bad) begin
        checks++;
        if (wb.result_ready !== exp_rdy) begin
          failures++;
          ready_bad = 1'b1;
          $display("FAIL rand_ready@%0d: got %b want %b (accepted=%0d written=%0d)", cyc, wb.result_ready, exp_rdy, acc, obs_addr.size());
        end
      end
    end
    checks++; if (fin_cnt != 1) begin failures++; $display("FAIL rand_finish: got %0d pulses want 1 within budget", fin_cnt); end
    checks++; if (acc != TOTAL) begin failures++; $display("FAIL rand_accepted: got %0d want %0d", acc, TOTAL); end
    checks++; if (obs_addr.size() != TOTAL) begin failures++; $display("FAIL rand_count: got %0d writes want %0d", obs_addr.size(), TOTAL); end
    for (int i = 0; i < obs_addr.size() && i < TOTAL; i++) begin
      exp_d = (r && $signed(vals[i]) < 0) ? '0 : vals[i];
      checks++;
      if (obs_addr[i] !== base + AW'(i) || obs_data[i] !== exp_d) begin
        failures++;
        $display("FAIL rand_write%0d: got (%h,%h) want (%h,%h)", i, obs_addr[i], obs_data[i], base + AW'(i), exp_d);
        break;
      end
    end
    feed_q.delete();
    repeat (4) tick();
    checks++; if (fin_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL rand_after: got pulses=%0d busy=%b want 1,0", fin_cnt, busy); end
  endtask

  task automatic test_reset_midjob();
    feed_q    = {16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18, 16'd19};
    valid_pct = 100;
    grant_pct = 100;
    do_start(16'h0A00, 5'd3, 1'b0);
    for (int i = 0; i < 60 && obs_addr.size() < 5; i++) tick();
    checks++; if (obs_addr.size() != 5) begin failures++; $display("FAIL mid_reach5: got %0d writes want 5", obs_addr.size()); end
    feed_q.delete();
    wb.result_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb.result_ready !== 1'b0 || wb.RAM_write !== 1'b0 || busy !== 1'b0 || finish_write !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_ctl: got ready=%b write=%b busy=%b finish=%b want all 0", wb.result_ready, wb.RAM_write, busy, finish_write);
    end
    checks++; if (wb.RAM_address !== 16'h0000 || wb.RAM_bus !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_bus: got addr=%h bus=%h want 0000,0000", wb.RAM_address, wb.RAM_bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_addr.delete();
    fin_cnt = 0;
    repeat (5) tick();
    checks++; if (fin_cnt != 0 || obs_addr.size() != 0) begin failures++; $display("FAIL mid_abandon: got pulses=%0d writes=%0d want 0,0", fin_cnt, obs_addr.size()); end
    feed_q = {16'h0101, 16'h0202, 16'h0303, 16'h0404};
    do_start(16'h0200, 5'd2, 1'b0);
    repeat (12) tick();
    checks++; if (obs_addr.size() != 4 || fin_cnt != 1) begin failures++; $display("FAIL mid_restart: got writes=%0d pulses=%0d want 4,1", obs_addr.size(), fin_cnt); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== 16'h0200 + 16'(i) || obs_data[i] !== 16'h0101 * 16'(i + 1)) begin
        failures++;
        $display("FAIL mid_restart_write%0d: got (%h,%h) want (%h,%h)", i, obs_addr[i], obs_data[i], 16'h0200 + 16'(i), 16'h0101 * 16'(i + 1));
      end
    end
  endtask

  initial begin
    start           = 1'b0;
    address         = '0;
    out_size        = 5'd0;
    relu            = 1'b0;
    wb.result_valid = 1'b0;
    wb.result_data  = '0;
    wb.RAM_grant    = 1'b0;
    valid_pct       = 100;
    grant_pct       = 100;
    cyc = 0; acc = 0; fin_cnt = 0; fin_cyc = -1; ready_seen = 0;
    test_reset();
    test_basic();
    test_relu_wrap();
    test_backpressure();
    test_degenerate();
    test_random();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
